// File: rtl/axis_frame_normalizer.sv
// AXI-Stream frame-length normalizer: pads short frames, truncates long ones,
// optional skid-buffered output and per-frame pad/drop statistics.
module axis_frame_normalizer #(
  parameter int               DATA_W    = 64,
  parameter int               CNT_W     = 32,
  parameter logic [DATA_W-1:0] PAD_VALUE = {DATA_W{1'b0}},
  parameter bit               TRUNC_EN  = 1'b1,
  parameter bit               OUT_REG   = 1'b1
) (
  input  logic              s_axis_aclk,
  input  logic              s_axis_areset,
  input  logic [CNT_W-1:0]  frame_len,
  output logic              s_axis_tready,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tlast,
  input  logic              s_axis_tvalid,
  input  logic              m_axis_tready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tlast,
  output logic              m_axis_tvalid,
  output logic              m_axis_hsked,
  output logic              frame_done,
  output logic [CNT_W-1:0]  pad_beats,
  output logic [CNT_W-1:0]  drop_beats
);

  typedef enum logic [1:0] {
    PASS,
    PAD,
    DROP
  } state_t;

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] MAX = {CNT_W{1'b1}};

  state_t            state;
  logic              run;
  logic [CNT_W-1:0]  beat_cnt;
  logic [CNT_W-1:0]  len_q;
  logic [CNT_W-1:0]  len_in;
  logic [CNT_W-1:0]  len_eff;
  logic [CNT_W-1:0]  pad_cnt;
  logic [CNT_W-1:0]  drop_cnt;
  logic              at_len;
  logic              ge_len;
  logic              core_valid;
  logic              core_ready;
  logic              core_tlast;
  logic              core_hs;
  logic              s_hs;
  logic [DATA_W-1:0] core_data;

  assign len_in  = (frame_len == '0) ? ONE : frame_len;
  assign len_eff = (beat_cnt == ONE) ? len_in : len_q;
  assign at_len  = (beat_cnt == len_eff);
  assign ge_len  = (beat_cnt >= len_eff);

  // run keeps every valid/ready low while reset is held
  always_comb begin
    core_valid    = 1'b0;
    core_data     = s_axis_tdata;
    core_tlast    = 1'b0;
    s_axis_tready = 1'b0;
    unique case (state)
      PASS: begin
        core_valid    = run && s_axis_tvalid;
        s_axis_tready = core_ready;
        core_tlast    = (s_axis_tlast && ge_len) ||
                        (TRUNC_EN && at_len);
      end
      PAD: begin
        core_valid = run;
        core_data  = PAD_VALUE;
        core_tlast = (beat_cnt == len_q);
      end
      DROP: begin
        s_axis_tready = run;
      end
      default: ;
    endcase
  end

  assign core_hs = core_valid && core_ready;
  assign s_hs    = s_axis_tvalid && s_axis_tready;

  always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
    if (s_axis_areset) begin
      state      <= PASS;
      run        <= 1'b0;
      beat_cnt   <= ONE;
      len_q      <= ONE;
      pad_cnt    <= '0;
      drop_cnt   <= '0;
      pad_beats  <= '0;
      drop_beats <= '0;
    end else begin
      run <= 1'b1;
      if (core_hs) begin
        if (beat_cnt == ONE) len_q <= len_eff;
        if (core_tlast) beat_cnt <= ONE;
        else if (beat_cnt != MAX) beat_cnt <= beat_cnt + ONE;
      end
      unique case (state)
        PASS: begin
          if (core_hs) begin
            if (s_axis_tlast && !ge_len) begin
              state   <= PAD;
              pad_cnt <= '0;
            end else if (core_tlast) begin
              pad_beats <= '0;
              // tlast without s_tlast only happens on a truncation
              if (!s_axis_tlast) begin
                state    <= DROP;
                drop_cnt <= '0;
              end else begin
                drop_beats <= '0;
              end
            end
          end
        end
        PAD: begin
          if (core_hs) begin
            pad_cnt <= pad_cnt + ONE;
            if (core_tlast) begin
              state      <= PASS;
              pad_beats  <= pad_cnt + ONE;
              drop_beats <= '0;
            end
          end
        end
        DROP: begin
          if (s_hs) begin
            drop_cnt <= drop_cnt + ONE;
            if (s_axis_tlast) begin
              state      <= PASS;
              drop_beats <= drop_cnt + ONE;
            end
          end
        end
        default: state <= PASS;
      endcase
    end
  end

  generate
    if (OUT_REG) begin : g_skid
      logic              out_valid;
      logic              out_last;
      logic [DATA_W-1:0] out_data;
      logic              skid_valid;
      logic              skid_last;
      logic [DATA_W-1:0] skid_data;

      assign core_ready = run && !skid_valid;

      always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
        if (s_axis_areset) begin
          out_valid  <= 1'b0;
          out_last   <= 1'b0;
          out_data   <= '0;
          skid_valid <= 1'b0;
          skid_last  <= 1'b0;
          skid_data  <= '0;
        end else if (!out_valid || m_axis_tready) begin
          if (skid_valid) begin
            out_valid  <= 1'b1;
            out_data   <= skid_data;
            out_last   <= skid_last;
            skid_valid <= 1'b0;
          end else begin
            out_valid <= core_hs;
            if (core_hs) begin
              out_data <= core_data;
              out_last <= core_tlast;
            end
          end
        end else if (core_hs) begin
          skid_valid <= 1'b1;
          skid_data  <= core_data;
          skid_last  <= core_tlast;
        end
      end

      assign m_axis_tvalid = out_valid;
      assign m_axis_tdata  = out_data;
      assign m_axis_tlast  = out_valid && out_last;
    end else begin : g_comb
      assign core_ready    = run && m_axis_tready;
      assign m_axis_tvalid = core_valid;
      assign m_axis_tdata  = run ? core_data : '0;
      assign m_axis_tlast  = run && core_tlast;
    end
  endgenerate

  assign m_axis_hsked = m_axis_tvalid && m_axis_tready;

  always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
    if (s_axis_areset) frame_done <= 1'b0;
    else frame_done <= m_axis_hsked && m_axis_tlast;
  end

endmodule

// File: tb/tb_axis_frame_normalizer.sv
// Scoreboard bench: three normalizer configurations driven by directed frames,
// expected beats queued at issue time and checked by an independent monitor.
module tb_axis_frame_normalizer;

  typedef struct packed {
    logic [15:0] data;
    logic        last;
  } beat_t;

  logic        clk;
  logic [2:0]  rst;
  logic [7:0]  frame_len [3];
  logic [2:0]  s_tready;
  logic [15:0] s_tdata [3];
  logic [2:0]  s_tlast;
  logic [2:0]  s_tvalid;
  logic [2:0]  m_tready;
  logic [15:0] m_tdata [3];
  logic [2:0]  m_tlast;
  logic [2:0]  m_tvalid;
  logic [2:0]  m_hsked;
  logic [2:0]  frame_done;
  logic [7:0]  pad_b [3];
  logic [7:0]  drop_b [3];

  beat_t exp_q [3][$];
  int    n_cmp = 0;
  int    n_err = 0;
  int    frames_exp [3];
  int    done_cnt [3];

  genvar g;
  generate
    for (g = 0; g < 3; g++) begin : g_dut
      axis_frame_normalizer #(
        .DATA_W   (16),
        .CNT_W    (8),
        .PAD_VALUE((g == 2) ? 16'hA5A5 : 16'h0000),
        .TRUNC_EN (g != 1),
        .OUT_REG  (g == 2)
      ) u_dut (
        .s_axis_aclk  (clk),
        .s_axis_areset(rst[g]),
        .frame_len    (frame_len[g]),
        .s_axis_tready(s_tready[g]),
        .s_axis_tdata (s_tdata[g]),
        .s_axis_tlast (s_tlast[g]),
        .s_axis_tvalid(s_tvalid[g]),
        .m_axis_tready(m_tready[g]),
        .m_axis_tdata (m_tdata[g]),
        .m_axis_tlast (m_tlast[g]),
        .m_axis_tvalid(m_tvalid[g]),
        .m_axis_hsked (m_hsked[g]),
        .frame_done   (frame_done[g]),
        .pad_beats    (pad_b[g]),
        .drop_beats   (drop_b[g])
      );
    end
  endgenerate

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h @%0t", nm, act, exp, $time);
    end
  endtask

  // frame-level reference: pad to len, or cut to len when truncating
  task automatic expect_frame(input int d, input int n, input int len,
                              input logic [15:0] base);
    int    L;
    int    nout;
    beat_t b;
    L = (len == 0) ? 1 : len;
    if (n >= L) nout = (d != 1) ? L : n;
    else nout = L;
    for (int i = 0; i < nout; i++) begin
      if (i < n) b.data = base + 16'(i);
      else b.data = (d == 2) ? 16'hA5A5 : 16'h0000;
      b.last = (i == nout - 1);
      exp_q[d].push_back(b);
    end
    frames_exp[d]++;
  endtask

  task automatic send_frame(input int d, input int n, input logic [15:0] base,
                            input int chg_at, input logic [7:0] chg_len);
    int w;
    @(posedge clk);
    #1;
    for (int i = 0; i < n; i++) begin
      s_tvalid[d] = 1'b1;
      s_tdata[d]  = base + 16'(i);
      s_tlast[d]  = (i == n - 1);
      w = 0;
      @(negedge clk);
      while (!s_tready[d] && w < 2000) begin
        @(negedge clk);
        w++;
      end
      if (w >= 2000) begin
        n_cmp++;
        n_err++;
        $display("FAIL d%0d_s_ready_timeout: got 0 expected 1", d);
      end
      @(posedge clk);
      #1;
      if (i == chg_at) frame_len[d] = chg_len;
    end
    s_tvalid[d] = 1'b0;
    s_tlast[d]  = 1'b0;
  endtask

  task automatic drain(input int d);
    int w;
    w = 0;
    while (exp_q[d].size() != 0 && w < 5000) begin
      @(negedge clk);
      w++;
    end
    if (w >= 5000) begin
      n_cmp++;
      n_err++;
      $display("FAIL d%0d_drain_timeout: got %0d left expected 0",
               d, exp_q[d].size());
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    m_tready = 3'b111;
    forever begin
      @(posedge clk);
      #1;
      m_tready[1] = 1'($urandom_range(0, 1));
      m_tready[2] = 1'($urandom_range(0, 1));
    end
  end

  // monitor: scoreboard pops, hold-while-stalled and frame_done timing
  initial begin
    logic [2:0]  prev_tl;
    logic [2:0]  stall;
    logic [15:0] hold_d [3];
    logic [2:0]  hold_l;
    beat_t       e;
    prev_tl = '0;
    stall   = '0;
    hold_l  = '0;
    for (int d = 0; d < 3; d++) hold_d[d] = '0;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        if (rst[d]) begin
          prev_tl[d] = 1'b0;
          stall[d]   = 1'b0;
        end else begin
          chk($sformatf("d%0d_frame_done", d), 32'(frame_done[d]),
              32'(prev_tl[d]));
          if (frame_done[d]) done_cnt[d]++;
          if (stall[d]) begin
            chk($sformatf("d%0d_hold_valid", d), 32'(m_tvalid[d]), 32'd1);
            chk($sformatf("d%0d_hold_data", d), 32'(m_tdata[d]),
                32'(hold_d[d]));
            chk($sformatf("d%0d_hold_last", d), 32'(m_tlast[d]),
                32'(hold_l[d]));
          end
          if (m_tvalid[d] && m_tready[d]) begin
            if (exp_q[d].size() == 0) begin
              n_cmp++;
              n_err++;
              $display("FAIL d%0d_extra_beat: got %0h expected none",
                       d, m_tdata[d]);
            end else begin
              e = exp_q[d].pop_front();
              chk($sformatf("d%0d_data", d), 32'(m_tdata[d]), 32'(e.data));
              chk($sformatf("d%0d_last", d), 32'(m_tlast[d]), 32'(e.last));
            end
          end
          prev_tl[d] = m_tvalid[d] && m_tready[d] && m_tlast[d];
          stall[d]   = m_tvalid[d] && !m_tready[d];
          hold_d[d]  = m_tdata[d];
          hold_l[d]  = m_tlast[d];
        end
      end
    end
  end

  initial begin
    int          n;
    logic [15:0] base;
    rst      = 3'b111;
    s_tvalid = '0;
    s_tlast  = '0;
    for (int d = 0; d < 3; d++) begin
      s_tdata[d]    = '0;
      frame_len[d]  = 8'd4;
      frames_exp[d] = 0;
      done_cnt[d]   = 0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("d%0d_rst_valid", d), 32'(m_tvalid[d]), 32'd0);
      chk($sformatf("d%0d_rst_last", d), 32'(m_tlast[d]), 32'd0);
      chk($sformatf("d%0d_rst_data", d), 32'(m_tdata[d]), 32'd0);
      chk($sformatf("d%0d_rst_sready", d), 32'(s_tready[d]), 32'd0);
      chk($sformatf("d%0d_rst_done", d), 32'(frame_done[d]), 32'd0);
      chk($sformatf("d%0d_rst_pad", d), 32'(pad_b[d]), 32'd0);
      chk($sformatf("d%0d_rst_drop", d), 32'(drop_b[d]), 32'd0);
    end
    @(posedge clk);
    #1;
    rst = 3'b000;

    frame_len[0] = 8'd4;
    expect_frame(0, 4, 4, 16'h0A00);
    send_frame(0, 4, 16'h0A00, -1, 8'd0);
    @(negedge clk);
    chk("exact_pad", 32'(pad_b[0]), 32'd0);
    chk("exact_drop", 32'(drop_b[0]), 32'd0);

    frame_len[0] = 8'd5;
    expect_frame(0, 2, 5, 16'h0B00);
    send_frame(0, 2, 16'h0B00, -1, 8'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("short_sready_pad", 32'(s_tready[0]), 32'd0);
      chk("short_valid_pad", 32'(m_tvalid[0]), 32'd1);
    end
    @(negedge clk);
    chk("short_pad", 32'(pad_b[0]), 32'd3);
    chk("short_drop", 32'(drop_b[0]), 32'd0);
    chk("short_sready_after", 32'(s_tready[0]), 32'd1);

    frame_len[0] = 8'd3;
    expect_frame(0, 6, 3, 16'h0C00);
    send_frame(0, 6, 16'h0C00, -1, 8'd0);
    chk("long_drop", 32'(drop_b[0]), 32'd3);
    chk("long_pad", 32'(pad_b[0]), 32'd0);
    expect_frame(0, 3, 3, 16'h0D00);
    send_frame(0, 3, 16'h0D00, -1, 8'd0);
    chk("after_long_drop", 32'(drop_b[0]), 32'd0);

    frame_len[0] = 8'd0;
    expect_frame(0, 3, 0, 16'h0E00);
    send_frame(0, 3, 16'h0E00, -1, 8'd0);
    chk("len0_drop", 32'(drop_b[0]), 32'd2);
    expect_frame(0, 1, 0, 16'h0E10);
    send_frame(0, 1, 16'h0E10, -1, 8'd0);

    frame_len[0] = 8'd4;
    expect_frame(0, 4, 4, 16'h0F00);
    send_frame(0, 4, 16'h0F00, 0, 8'd2);
    expect_frame(0, 2, 2, 16'h0F10);
    send_frame(0, 2, 16'h0F10, -1, 8'd0);
    drain(0);

    frame_len[0] = 8'd5;
    expect_frame(0, 2, 5, 16'h1100);
    send_frame(0, 2, 16'h1100, -1, 8'd0);
    @(posedge clk);
    #4;
    rst[0] = 1'b1;
    #1;
    chk("midrst_valid", 32'(m_tvalid[0]), 32'd0);
    chk("midrst_last", 32'(m_tlast[0]), 32'd0);
    chk("midrst_sready", 32'(s_tready[0]), 32'd0);
    chk("midrst_pad", 32'(pad_b[0]), 32'd0);
    exp_q[0].delete();
    frames_exp[0]--;
    @(negedge clk);
    #1;
    rst[0] = 1'b0;
    expect_frame(0, 5, 5, 16'h1200);
    send_frame(0, 5, 16'h1200, -1, 8'd0);
    drain(0);

    frame_len[1] = 8'd3;
    expect_frame(1, 6, 3, 16'h2000);
    send_frame(1, 6, 16'h2000, -1, 8'd0);
    drain(1);
    chk("notrunc_drop", 32'(drop_b[1]), 32'd0);
    chk("notrunc_pad", 32'(pad_b[1]), 32'd0);
    expect_frame(1, 2, 3, 16'h2100);
    send_frame(1, 2, 16'h2100, -1, 8'd0);
    drain(1);
    chk("notrunc_short_pad", 32'(pad_b[1]), 32'd1);

    frame_len[2] = 8'd8;
    for (int f = 0; f < 1000; f++) begin
      n    = $urandom_range(1, 16);
      base = 16'($urandom);
      expect_frame(2, n, 8, base);
      send_frame(2, n, base, -1, 8'd0);
      if (n > 8) chk("bp_drop", 32'(drop_b[2]), 32'(n - 8));
    end

    for (int d = 0; d < 3; d++) begin
      drain(d);
      chk($sformatf("d%0d_frames", d), 32'(done_cnt[d]),
          32'(frames_exp[d]));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/axis_frame_normalizer.md
Name: axis_frame_normalizer

Overview:
- Parametrised AXI-Stream frame-length normalizer between the PAICORE output FIFO and the DMA write channel.
- Every output frame has exactly the programmed number of beats:
  - short frames are padded with PAD_VALUE beats;
  - long frames are truncated, with the excess dropped, when TRUNC_EN=1.
- Optional skid-buffered output register for timing closure.
- Per-frame status counters give software the pad and drop statistics.

Parameters:
- DATA_W, 64, tdata width in bits.
- CNT_W, 32, width of frame_len, the beat counter and the status counters.
- PAD_VALUE, {DATA_W{1'b0}}, tdata value of padding beats.
- TRUNC_EN, 1, 1 = cut frames longer than frame_len; 0 = pass long frames unmodified.
- OUT_REG, 1, 1 = 2-entry skid buffer on the m_axis side; 0 = combinational output path.

Ports:
- s_axis_aclk  in  1  single clock for all logic.
- s_axis_areset  in  1  asynchronous, active-high reset.
- frame_len  in  CNT_W  target beats per output frame; 0 is treated as 1.
- s_axis_tready  out  1  upstream ready.
- s_axis_tdata  in  DATA_W  upstream data.
- s_axis_tlast  in  1  upstream end of frame.
- s_axis_tvalid  in  1  upstream valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tdata  out  DATA_W  downstream data.
- m_axis_tlast  out  1  downstream end of frame.
- m_axis_tvalid  out  1  downstream valid.
- m_axis_hsked  out  1  m_axis_tvalid && m_axis_tready.
- frame_done  out  1  one-cycle pulse on each m_axis tlast handshake.
- pad_beats  out  CNT_W  pad beats emitted in the last completed frame.
- drop_beats  out  CNT_W  input beats discarded in the last completed input frame.

Behaviour:

Reset:
- All outputs go to 0 asynchronously: tvalid, tlast, tdata, frame_done, pad_beats, drop_beats; s_axis_tready deasserts.
- Internal state: FSM=PASS, beat_cnt=1, skid buffer empty.
- Reset mid-frame abandons the frame; no tlast is emitted for it.

Core-side handshake:
- The internal core handshake (core_hs) is core_valid && core_ready.
- core_ready = m_axis_tready when OUT_REG=0; otherwise it is "skid not full".

Length latching:
- len_eff = (beat_cnt==1) ? max(frame_len,1) : len_q.
- len_q <= len_eff on every core_hs at beat_cnt==1.
- Changes to frame_len mid-frame are ignored.

Beat counter:
- beat_cnt is the 1-based index of the beat currently presented.
- +1 on each core_hs; returns to 1 on a core_hs with tlast.
- Never wraps because len_eff <= 2^CNT_W-1; saturates at all-ones if TRUNC_EN=0 and a frame exceeds that.

FSM states:
- PASS:
  - core_valid = s_axis_tvalid; s_axis_tready = core_ready; data passes through.
  - core_tlast = (s_tlast && beat_cnt>=len_eff) || (TRUNC_EN && beat_cnt==len_eff).
  - s_tlast && beat_cnt<len_eff on handshake -> PAD.
  - beat_cnt==len_eff && !s_tlast && TRUNC_EN on handshake -> DROP.
- PAD:
  - s_axis_tready=0; core_valid=1; data=PAD_VALUE; core_tlast=(beat_cnt==len_q).
  - The tlast handshake -> PASS.
- DROP:
  - s_axis_tready=1; core_valid=0; input beats are discarded and counted.
  - The s_tlast handshake -> PASS.
  - No output is produced; a new frame may start the next cycle.

Status counters:
- pad_beats and drop_beats are working counters, cleared at frame start.
- Their values are published to the outputs when the frame completes:
  - pad_beats at the PAD tlast handshake;
  - drop_beats at the DROP-exit handshake, or 0 if the frame had no drop.
- frame_done is registered and asserts the cycle after the m_axis tlast handshake.

Output stage:
- OUT_REG=0: m_axis_* = core_*, zero latency.
- OUT_REG=1: skid buffer, 1-cycle latency, full throughput.
  - Registered tvalid/tdata/tlast; core_ready is registered.
  - No beat is lost or duplicated under any m_axis_tready pattern.

Simultaneous events:
- An s_tlast beat with beat_cnt==len_eff ends the frame normally; no PAD, no DROP.
- A frame of length exactly len passes unchanged.
- Backpressure in PAD holds the current pad beat stable; tdata and tlast are constant while valid && !ready.

Test Plan:
- Exact length, OUT_REG=0: frame_len=4, input 4 beats A,B,C,D with tlast on D -> output identical, tlast on D, pad_beats=0, drop_beats=0, one frame_done pulse.
- Short frame: frame_len=5, input 2 beats with tlast on the 2nd -> output A,B,0,0,0 with tlast on beat 5, s_axis_tready=0 during the 3 pad beats, pad_beats=3.
- Long frame, TRUNC_EN=1: frame_len=3, input 6 beats -> output 3 beats with tlast on the 3rd, 3 beats consumed with no output, drop_beats=3; the next frame's first beat is output as beat 1. With TRUNC_EN=0 -> 6 beats out, tlast on the 6th.
- Backpressure, OUT_REG=1: random m_axis_tready at 50%, 1000 frames with random lengths 1..16 and frame_len=8 -> scoreboard matches exactly, every output frame is 8 beats, data stable while stalled.
- Edge length: frame_len=0 -> every frame is 1 beat. frame_len changed from 4 to 2 mid-frame -> current frame is still 4 beats, next frame is 2 beats.
- Reset mid-frame: assert s_axis_areset during PAD beat 2 -> m_axis_tvalid=0 immediately, no tlast emitted; after release the next frame is normal from beat 1.
